// File: rtl/router_pkg.sv
// Shared constants and types for the 1x3 router datapath.
// Header byte layout: length in bits [7:2], destination port in bits [1:0].
package router_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int FIFO_DEPTH      = 16;
    localparam int FIFO_ADDR_WIDTH = 4;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_DEST_MSB = 1;
    localparam int HDR_DEST_LSB = 0;

    // Payload length carried in a header (6 bits covers 0..63 bytes).
    typedef logic [HDR_LEN_MSB-HDR_LEN_LSB:0] pkt_len_t;

    // Extracts the payload length field from a header byte.
    function automatic pkt_len_t hdr_len(input logic [DATA_WIDTH-1:0] hdr);
        return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

    // Extracts the destination field from a header byte.
    function automatic logic [HDR_DEST_MSB:0] hdr_dest(input logic [DATA_WIDTH-1:0] hdr);
        return hdr[HDR_DEST_MSB:HDR_DEST_LSB];
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router.
// Each stored word carries a header tag bit so the read side can load the
// packet length and blank data_out once the parity byte has gone out.
module router_fifo #(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
    parameter int DEPTH      = router_pkg::FIFO_DEPTH,
    parameter int ADDR_WIDTH = router_pkg::FIFO_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  read_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] data_out
);

    import router_pkg::*;

    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
    localparam pkt_len_t            PKT_ONE = pkt_len_t'(1);

    // Bit DATA_WIDTH of each word is the header tag.
    logic [DATA_WIDTH:0]   mem [DEPTH];

    logic [ADDR_WIDTH:0]   wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH:0]   rdPtr_q, rdPtr_d;
    pkt_len_t              pktCnt_q, pktCnt_d;
    logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;

    logic                  wrAccept;
    logic                  rdAccept;
    logic                  flush;
    logic [DATA_WIDTH:0]   rdWord;

    assign empty    = (wrPtr_q == rdPtr_q);
    assign full     = (wrPtr_q[ADDR_WIDTH] != rdPtr_q[ADDR_WIDTH]) &&
                      (wrPtr_q[ADDR_WIDTH-1:0] == rdPtr_q[ADDR_WIDTH-1:0]);
    assign wrAccept = write_enb && !full;
    assign rdAccept = read_enb && !empty;
    assign flush    = reset || soft_reset;
    assign rdWord   = mem[rdPtr_q[ADDR_WIDTH-1:0]];
    assign data_out = dataOut_q;

    // Storage write; no reset on the array, a flush only blocks the write.
    always_ff @(posedge clock) begin
        if (!flush && wrAccept) begin
            mem[wrPtr_q[ADDR_WIDTH-1:0]] <= {lfd_state, data_in};
        end
    end

    // Next pointers, packet countdown and read data for this cycle.
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        pktCnt_d  = pktCnt_q;
        dataOut_d = dataOut_q;

        if (wrAccept) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end

        if (rdAccept) begin
            rdPtr_d   = rdPtr_q + PTR_ONE;
            dataOut_d = rdWord[DATA_WIDTH-1:0];
            if (rdWord[DATA_WIDTH]) begin
                // Header: remaining bytes are the payload plus one parity byte.
                pktCnt_d = hdr_len(rdWord[DATA_WIDTH-1:0]) + PKT_ONE;
            end else if (pktCnt_q != '0) begin
                pktCnt_d = pktCnt_q - PKT_ONE;
            end
        end else if (pktCnt_q == '0) begin
            dataOut_d = '0;
        end
    end

    // State register; hard reset first, then the per-port soft flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            pktCnt_q  <= '0;
            dataOut_q <= '0;
        end else if (soft_reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            pktCnt_q  <= '0;
            dataOut_q <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            pktCnt_q  <= pktCnt_d;
            dataOut_q <= dataOut_d;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: a word-level scoreboard tracks every
// accepted write and read, plus a table of packet vectors and corner sequences.
module tb_router_fifo;

    localparam int DEPTH = 16;

    logic       clock;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       full;
    logic       empty;
    logic [7:0] data_out;

    int total = 0;
    int bad   = 0;

    logic [8:0] modelQ[$];
    logic [5:0] modelPkt;
    logic [7:0] modelOut;

    typedef struct {
        logic       we;
        logic       re;
        logic       lfd;
        logic [7:0] din;
        logic [7:0] expOut;
        logic       expEmpty;
        logic       expFull;
        logic [5:0] expPkt;
    } vec_t;

    vec_t vecs[11];

    router_fifo dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .full       (full),
        .empty      (empty),
        .data_out   (data_out)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus; the scoreboard decides what the DUT must do.
    task automatic applyStimulus(input logic we, input logic re, input logic lfd,
                                 input logic [7:0] din, input logic sr);
        logic       rdOk;
        logic       wrOk;
        logic [8:0] word;
        checkOutput("emptyFlag", {31'd0, empty}, {31'd0, modelQ.size() == 0});
        checkOutput("fullFlag", {31'd0, full}, {31'd0, modelQ.size() == DEPTH});
        checkOutput("emptyAndFull", {31'd0, empty & full}, 32'd0);
        rdOk = re && (modelQ.size() != 0) && !sr;
        wrOk = we && (modelQ.size() != DEPTH) && !sr;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        soft_reset = sr;
        @(posedge clock);
        #1;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        soft_reset = 1'b0;
        if (sr) begin
            modelQ.delete();
            modelPkt = 6'd0;
            modelOut = 8'h00;
        end else begin
            if (rdOk) begin
                word     = modelQ.pop_front();
                modelOut = word[7:0];
                if (word[8]) begin
                    modelPkt = word[7:2] + 6'd1;
                end else if (modelPkt != 6'd0) begin
                    modelPkt = modelPkt - 6'd1;
                end
            end else if (modelPkt == 6'd0) begin
                modelOut = 8'h00;
            end
            if (wrOk) begin
                modelQ.push_back({lfd, din});
            end
        end
        checkOutput("dataOut", {24'd0, data_out}, {24'd0, modelOut});
        checkOutput("pktCnt", {26'd0, dut.pktCnt_q}, {26'd0, modelPkt});
    endtask

    task automatic applyReset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        modelQ.delete();
        modelPkt = 6'd0;
        modelOut = 8'h00;
        checkOutput("resetEmpty", {31'd0, empty}, 32'd1);
        checkOutput("resetFull", {31'd0, full}, 32'd0);
        checkOutput("resetDataOut", {24'd0, data_out}, 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        modelPkt   = 6'd0;
        modelOut   = 8'h00;

        // Header 0x0D = length 3, dest 1; then three payload bytes and parity.
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h0D, 8'h00, 1'b0, 1'b0, 6'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'hA1, 8'h00, 1'b0, 1'b0, 6'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'hA2, 8'h00, 1'b0, 1'b0, 6'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'hA3, 8'h00, 1'b0, 1'b0, 6'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h5F, 8'h00, 1'b0, 1'b0, 6'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h0D, 1'b0, 1'b0, 6'd4};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA1, 1'b0, 1'b0, 6'd3};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA2, 1'b0, 1'b0, 6'd2};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA3, 1'b0, 1'b0, 6'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h5F, 1'b1, 1'b0, 6'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 6'd0};

        // Hard reset, then soft reset after five writes.
        applyReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h30 + i), 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("softRstEmpty", {31'd0, empty}, 32'd1);
        checkOutput("softRstFull", {31'd0, full}, 32'd0);
        checkOutput("softRstDataOut", {24'd0, data_out}, 32'd0);

        // Table-driven packet write and read-back.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].we, vecs[i].re, vecs[i].lfd, vecs[i].din, 1'b0);
            checkOutput("tblDataOut", {24'd0, data_out}, {24'd0, vecs[i].expOut});
            checkOutput("tblEmpty", {31'd0, empty}, {31'd0, vecs[i].expEmpty});
            checkOutput("tblFull", {31'd0, full}, {31'd0, vecs[i].expFull});
            checkOutput("tblPktCnt", {26'd0, dut.pktCnt_q}, {26'd0, vecs[i].expPkt});
        end

        // Fill to full, then an overflow write that must be dropped.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'(i), 1'b0);
        end
        checkOutput("fillFull", {31'd0, full}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        checkOutput("overflowStillFull", {31'd0, full}, 32'd1);

        // Read and write together while full: only the read happens.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
        checkOutput("fullRdWrData", {24'd0, data_out}, 32'h00);
        checkOutput("fullRdWrFull", {31'd0, full}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end
        checkOutput("occ8Size", modelQ.size(), 32'd8);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end
        checkOutput("drainEmpty", {31'd0, empty}, 32'd1);
        checkOutput("drainLast", {24'd0, data_out}, 32'h77);

        // Read while empty mid-packet: data_out holds the last byte.
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h14, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("hdrLen5Pkt", {26'd0, dut.pktCnt_q}, 32'd6);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("emptyReadHold", {24'd0, data_out}, 32'h14);
        checkOutput("emptyReadEmpty", {31'd0, empty}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h42, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("afterEmptyRead", {24'd0, data_out}, 32'h42);

        // Interleaved traffic across two pointer wraps.
        applyReset();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end

        // Soft reset mid-packet with a concurrent write.
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h0D, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hA1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hA2, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hA3, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h5F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end
        checkOutput("midPktCnt", {26'd0, dut.pktCnt_q}, 32'd2);
        checkOutput("midPktData", {24'd0, data_out}, 32'hA2);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h99, 1'b1);
        checkOutput("srEmpty", {31'd0, empty}, 32'd1);
        checkOutput("srPktCnt", {26'd0, dut.pktCnt_q}, 32'd0);
        checkOutput("srDataOut", {24'd0, data_out}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("srNoWrite", {31'd0, empty}, 32'd1);
        checkOutput("srNoData", {24'd0, data_out}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- One of three per-port output FIFOs in the 1x3 router. Sits directly downstream of the synchronizer: it accepts that block's one-hot write_enb bit and soft_reset bit for its own port, and it reports full/empty back to it.
- Buffers header, payload and parity bytes, and tags each header so the read side can track packet length.
- Its read side feeds the destination's data_out port under the destination's read_enb.

Parameters:
DATA_WIDTH, 8, byte width of router data path
DEPTH, 16, number of storage words (power of two)
ADDR_WIDTH, 4, log2(DEPTH); pointers are ADDR_WIDTH+1 bits

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
soft_reset  input  1  synchronous, active-high per-port flush from the synchronizer timeout
write_enb  input  1  write strobe for this port, from the synchronizer
read_enb  input  1  read strobe from the destination
lfd_state  input  1  high in the same cycle as the header byte write; stored as tag bit
data_in  input  DATA_WIDTH  byte from the router register stage
full  output  1  combinational; all DEPTH words occupied
empty  output  1  combinational; no words stored
data_out  output  DATA_WIDTH  registered read data

Behaviour:
- Storage:
  - DEPTH x (DATA_WIDTH+1) array. Bit DATA_WIDTH is the header tag, taken from lfd_state.
  - The storage array is not cleared by reset.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits index storage.
  - The MSB toggles on wrap, so pointers wrap naturally modulo 2*DEPTH.
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) and the low bits are equal.
  - Both flags are driven purely from the pointers, with no extra register stage.
- Write:
  - A write is accepted only when write_enb and not full, as sampled in the current cycle.
  - An accepted write stores {lfd_state, data_in} at wr_ptr and increments wr_ptr.
  - A write while full is dropped silently; no pointer change.
- Read:
  - A read is accepted only when read_enb and not empty, as sampled in the current cycle.
  - An accepted read loads data_out with the stored byte on the next edge (1-cycle latency) and increments rd_ptr.
  - A read while empty is ignored; data_out is unchanged.
- Simultaneous read and write:
  - Both operations proceed independently in the same cycle.
  - When full, only the read happens, so full deasserts the next cycle.
  - When empty, only the write happens; no same-cycle bypass to data_out.
- Packet counter (6-bit pkt_cnt):
  - On an accepted read of a tagged word: pkt_cnt <= data[7:2] + 1, i.e. payload length plus parity byte.
  - On an accepted read of an untagged word with pkt_cnt != 0: pkt_cnt <= pkt_cnt - 1.
  - An untagged read with pkt_cnt == 0 leaves the counter at 0. This is an error case, and data is still delivered.
- data_out idle rule: when pkt_cnt == 0 and no read is accepted in that cycle, data_out <= 0. After the parity byte has been presented for one cycle, data_out returns to 0.
- Reset:
  - reset has the highest priority.
  - wr_ptr, rd_ptr, pkt_cnt and data_out go to 0, so the port reads empty=1, full=0.
- Soft reset:
  - soft_reset has the next priority and has the same effect as reset for this instance only.
  - It overrides any write or read in the same cycle.
  - It may arrive mid-packet; any partial packet is discarded.

Decomposition:
- Shared package router_pkg holds:
  - DATA_WIDTH, FIFO_DEPTH and FIFO_ADDR_WIDTH constants.
  - The header-field positions: length = data[7:2], destination = data[1:0].
  - The 6-bit packet-length type.
- A single flat module; no sub-module is warranted. Three instances are built in the router top, one per destination.

Test Plan:
1. reset=1 for 1 cycle -> empty=1, full=0, data_out=0. Same result with soft_reset=1 after 5 prior writes.
2. Packet write then read:
   - Stimulus: write header 0x0D (length 3, dest 1) with lfd_state=1, then 0xA1, 0xA2, 0xA3 and parity 0x5F. Then assert read_enb for 5 cycles.
   - Response: data_out = 0x0D, 0xA1, 0xA2, 0xA3, 0x5F on consecutive cycles, each 1 cycle after its read. pkt_cnt goes 4, 3, 2, 1, 0. data_out=0 in the following cycle; empty=1 after the 5th read.
3. Fill and overflow:
   - Stimulus: 16 writes of 0x00..0x0F, then a 17th write of 0xFF.
   - Response: full=1 after the 16th write; the 17th is dropped. 16 reads return 0x00..0x0F with no 0xFF.
4. Full plus simultaneous access:
   - Stimulus: while full, write_enb=1 and read_enb=1 together.
   - Response: one read occurs, the write is blocked, full=0 next cycle.
   - Then write and read together at occupancy 8: occupancy stays 8.
5. Empty read and wrap-around:
   - read_enb while empty -> data_out and pointers unchanged.
   - 40 interleaved single writes and reads -> data order preserved across two pointer wraps; empty and full never both 1.
6. Mid-packet soft reset:
   - Stimulus: assert soft_reset after the header and 2 payload bytes have been read (pkt_cnt=2), in the same cycle as write_enb=1.
   - Response: next cycle empty=1, pkt_cnt=0, data_out=0, and the write is not stored.
